// File: rtl/dec_onehot_seq.sv
// Index sequencer with registered, enable-gated one-hot decode.
// Steps a modulo-OUT_W index up or down with a programmable dwell, optionally for one revolution.
module dec_onehot_seq #(
  parameter int IN_W    = 3,
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [IN_W-1:0]      in,
  input  logic                 run,
  input  logic                 once,
  input  logic                 dir,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [2**IN_W-1:0]   out,
  output logic [IN_W-1:0]      idx,
  output logic                 busy,
  output logic                 wrap
);

  localparam int OUT_W = 2**IN_W;
  localparam logic [IN_W:0] FULL_REV = (IN_W+1)'(OUT_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [IN_W-1:0]     idx_reg, idx_next;
  logic [DWELL_W-1:0]  dcnt_reg, dcnt_next;
  logic [IN_W:0]       scnt_reg, scnt_next;
  logic                once_reg, once_next;
  logic                wrap_reg, wrap_next;
  logic [OUT_W-1:0]    out_reg, out_next;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    dcnt_next  = dcnt_reg;
    scnt_next  = scnt_reg;
    once_next  = once_reg;
    wrap_next  = 1'b0;
    if (load) begin
      idx_next   = in;
      state_next = IDLE;
      dcnt_next  = '0;
      scnt_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (run) begin
            state_next = RUN;
            once_next  = once;
            dcnt_next  = '0;
            scnt_next  = '0;
          end
        end
        RUN: begin
          if (!run) begin
            state_next = IDLE;
          end else if (dcnt_reg == dwell) begin
            // Step edge: direction is taken fresh here so mid-run changes apply to the next step.
            dcnt_next = '0;
            scnt_next = scnt_reg + (IN_W+1)'(1);
            if (dir) begin
              idx_next  = idx_reg - IN_W'(1);
              wrap_next = (idx_reg == '0);
            end else begin
              idx_next  = idx_reg + IN_W'(1);
              wrap_next = (idx_reg == {IN_W{1'b1}});
            end
            if (once_reg && (scnt_next == FULL_REV)) begin
              state_next = DONE;
            end
          end else begin
            dcnt_next = dcnt_reg + DWELL_W'(1);
          end
        end
        DONE: begin
          if (!run) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Decode the next index so out and idx change on the same edge.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
    assign out_next[gi] = en && (idx_next == IN_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      dcnt_reg  <= '0;
      scnt_reg  <= '0;
      once_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      dcnt_reg  <= dcnt_next;
      scnt_reg  <= scnt_next;
      once_reg  <= once_next;
      wrap_reg  <= wrap_next;
      out_reg   <= out_next;
    end
  end

  assign out  = out_reg;
  assign idx  = idx_reg;
  assign busy = (state_reg == RUN);
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Scoreboard bench for dec_onehot_seq (IN_W=3, DWELL_W=4): directed scenarios then random traffic.
module tb_dec_onehot_seq;

  logic       clk = 1'b0;
  logic       rst, en, load, run, once, dir;
  logic [2:0] in;
  logic [3:0] dwell;
  logic [7:0] out;
  logic [2:0] idx;
  logic       busy, wrap;

  dec_onehot_seq #(.IN_W(3), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .in(in), .run(run),
    .once(once), .dir(dir), .dwell(dwell), .out(out), .idx(idx),
    .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] out;
    logic [2:0] idx;
    logic       busy;
    logic       wrap;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: 0 idle, 1 run, 2 done
  int         m_state;
  logic [2:0] m_idx;
  logic [3:0] m_dcnt;
  int         m_steps;
  logic       m_once;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step(output exp_t e);
    logic w;
    w = 1'b0;
    if (rst) begin
      m_state = 0; m_idx = 0; m_dcnt = 0; m_steps = 0; m_once = 0;
    end else if (load) begin
      m_idx = in; m_state = 0; m_dcnt = 0; m_steps = 0;
    end else if (m_state == 0) begin
      if (run) begin
        m_state = 1; m_once = once; m_dcnt = 0; m_steps = 0;
      end
    end else if (m_state == 1) begin
      if (!run) m_state = 0;
      else if (m_dcnt == dwell) begin
        w = dir ? (m_idx == 3'd0) : (m_idx == 3'd7);
        m_idx = dir ? 3'((m_idx + 7) % 8) : 3'((m_idx + 1) % 8);
        m_dcnt = 0;
        m_steps++;
        if (m_once && m_steps == 8) m_state = 2;
      end else m_dcnt = m_dcnt + 4'd1;
    end else begin
      if (!run) m_state = 0;
    end
    e.idx  = m_idx;
    e.out  = (!rst && en) ? (8'd1 << m_idx) : 8'd0;
    e.busy = (m_state == 1);
    e.wrap = w;
  endtask

  task automatic tick();
    exp_t e, q;
    model_step(e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    q = sbq.pop_front();
    check("idx", 32'(idx), 32'(q.idx));
    check("out", 32'(out), 32'(q.out));
    check("busy", 32'(busy), 32'(q.busy));
    check("wrap", 32'(wrap), 32'(q.wrap));
    $display("cyc rst=%0b ld=%0b run=%0b dir=%0b dw=%0d en=%0b -> idx=%0d out=%08b busy=%0b wrap=%0b",
             rst, load, run, dir, dwell, en, idx, out, busy, wrap);
  endtask

  task automatic do_load(input logic [2:0] v);
    load = 1'b1; in = v; tick(); load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; in = '0; run = 1'b0;
    once = 1'b0; dir = 1'b0; dwell = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0; en = 1'b1;
    tick();
    check("rst_out", 32'(out), 32'h01);
    check("rst_idx", 32'(idx), 32'd0);

    // Load and decode, then enable gating
    do_load(3'd5);
    check("load_out", 32'(out), 32'h20);
    en = 1'b0; tick();
    check("gate_out", 32'(out), 32'h00);
    check("gate_idx", 32'(idx), 32'd5);
    en = 1'b1;

    // Up run through wrap
    do_load(3'd6);
    run = 1'b1; dwell = 4'd0; dir = 1'b0;
    tick();
    tick(); check("up_7", 32'(idx), 32'd7);
    tick(); check("up_0", 32'(idx), 32'd0); check("up_wrap", 32'(wrap), 32'd1);
    tick(); check("up_1", 32'(idx), 32'd1); check("up_nowrap", 32'(wrap), 32'd0);
    run = 1'b0; tick();

    // Down run with dwell
    do_load(3'd0);
    run = 1'b1; dwell = 4'd2; dir = 1'b1;
    tick();
    repeat (3) tick();
    check("dn_7", 32'(idx), 32'd7); check("dn_wrap", 32'(wrap), 32'd1);
    repeat (3) tick();
    check("dn_6", 32'(idx), 32'd6);
    run = 1'b0; tick();

    // One revolution
    do_load(3'd3);
    run = 1'b1; once = 1'b1; dwell = 4'd0; dir = 1'b0;
    tick();
    repeat (8) tick();
    check("once_idx", 32'(idx), 32'd3); check("once_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("done_hold", 32'(idx), 32'd3);
    run = 1'b0; tick();
    run = 1'b1; once = 1'b0; tick();
    check("restart_busy", 32'(busy), 32'd1);

    // Load priority and reset mid-run
    tick(); tick();
    load = 1'b1; in = 3'd2; tick(); load = 1'b0;
    check("pri_idx", 32'(idx), 32'd2); check("pri_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_run_idx", 32'(idx), 32'd0); check("rst_run_out", 32'(out), 32'd0);
    run = 1'b0; tick();

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 29) == 0);
      in    = 3'($urandom_range(0, 7));
      run   = ($urandom_range(0, 9) != 0);
      once  = 1'($urandom_range(0, 1));
      dir   = ($urandom_range(0, 7) == 0) ? ~dir : dir;
      dwell = 4'($urandom_range(0, 3));
      en    = ($urandom_range(0, 5) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
